// File: rtl/mux_two_bit_reg_pkg.sv
// Shared constants for the 4:1 word selector: default width and select codes.
package mux_two_bit_reg_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned SEL_W     = 2;

  localparam logic [SEL_W-1:0] SEL_IN1 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_IN2 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_IN3 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_IN4 = 2'd3;

endpackage

// File: rtl/mux_two_bit_reg_mux4_comb.sv
// Combinational WIDTH-bit 4:1 selector driven by the shared select codes.
module mux4_comb
  import mux_two_bit_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] sel_word_c
);

  // All four codes are legal; the leading assignment only keeps the block latch-free.
  always_comb begin
    sel_word_c = in1;
    unique case (sel)
      SEL_IN1: sel_word_c = in1;
      SEL_IN2: sel_word_c = in2;
      SEL_IN3: sel_word_c = in3;
      SEL_IN4: sel_word_c = in4;
    endcase
  end

endmodule

// File: rtl/mux_two_bit_reg.sv
// 4:1 word selector with a combinational output and a registered, valid-qualified copy.
module mux_two_bit_reg
  import mux_two_bit_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [SEL_W-1:0] ctrlSlct,
  input  logic             sel_valid,
  output logic [WIDTH-1:0] muxOut_comb,
  output logic [WIDTH-1:0] muxOut,
  output logic             out_valid
);

  logic [WIDTH-1:0] sel_word_c;

  mux4_comb #(
    .WIDTH (WIDTH)
  ) u_mux4_comb (
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .in4        (in4),
    .sel        (ctrlSlct),
    .sel_word_c (sel_word_c)
  );

  assign muxOut_comb = sel_word_c;

  // Capture only qualified selections; the word holds otherwise, valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      muxOut    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (sel_valid) begin
        muxOut <= sel_word_c;
      end
      out_valid <= sel_valid;
    end
  end

endmodule

// File: tb/tb_mux_two_bit_reg.sv
// Self-checking bench: directed plan checks plus randomized traffic against a behavioural model.
module tb_mux_two_bit_reg;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
  logic [1:0]   ctrlSlct = '0;
  logic         sel_valid = 1'b0;
  logic [W-1:0] muxOut_comb, muxOut;
  logic         out_valid;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] exp_q = '0;
  logic         exp_v = 1'b0;

  mux_two_bit_reg #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in1         (in1),
    .in2         (in2),
    .in3         (in3),
    .in4         (in4),
    .ctrlSlct    (ctrlSlct),
    .sel_valid   (sel_valid),
    .muxOut_comb (muxOut_comb),
    .muxOut      (muxOut),
    .out_valid   (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pick(input logic [1:0] code);
    logic [W-1:0] words [4];
    words[0] = in1; words[1] = in2; words[2] = in3; words[3] = in4;
    return words[code];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the registered copy is the word chosen at the last qualified edge since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= '0;
      exp_v <= 1'b0;
    end else begin
      if (sel_valid) exp_q <= pick(ctrlSlct);
      exp_v <= sel_valid;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_comb", muxOut_comb, pick(ctrlSlct));
      check("model_reg", muxOut, exp_q);
      check("model_valid", W'(out_valid), W'(exp_v));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [W-1:0] a, b, c, d);
    in1 = a; in2 = b; in3 = c; in4 = d;
  endtask

  initial begin
    logic [W-1:0] sweep [4];
    sweep[0] = 16'd500; sweep[1] = 16'd350; sweep[2] = 16'd150; sweep[3] = 16'd10;

    // Reset with no clock edge yet
    #1;
    rst_n = 1'b0;
    set_words(16'd500, 16'd350, 16'd150, 16'd10);
    sel_valid = 1'b1;
    ctrlSlct = 2'd0;
    #1;
    check("reset_reg", muxOut, 16'd0);
    check("reset_valid", W'(out_valid), 16'd0);
    check("reset_comb", muxOut_comb, 16'd500);
    chk_en = 1'b1;
    cycle();
    cycle();
    check("reset_held", muxOut, 16'd0);
    rst_n = 1'b1;

    // Sweep all codes back to back
    for (int k = 0; k < 4; k++) begin
      ctrlSlct = 2'(k);
      #1;
      check("sweep_comb", muxOut_comb, sweep[k]);
      cycle();
      check("sweep_reg", muxOut, sweep[k]);
      check("sweep_valid", W'(out_valid), 16'd1);
    end

    // Equal inputs
    set_words(16'd300, 16'd300, 16'd100, 16'd1000);
    ctrlSlct = 2'd0;
    cycle();
    check("eq_sel0", muxOut, 16'd300);
    in3 = 16'd150; in4 = 16'd150;
    ctrlSlct = 2'd1;
    cycle();
    check("eq_sel1", muxOut, 16'd300);
    ctrlSlct = 2'd3;
    cycle();
    check("eq_sel3", muxOut, 16'd150);

    // Hold while not qualified
    set_words(16'd500, 16'd350, 16'd150, 16'd10);
    ctrlSlct = 2'd1;
    cycle();
    check("hold_cap", muxOut, 16'd350);
    sel_valid = 1'b0;
    in2 = 16'd77;
    ctrlSlct = 2'd2;
    #1;
    check("hold_comb", muxOut_comb, 16'd150);
    cycle();
    check("hold_reg", muxOut, 16'd350);
    check("hold_valid", W'(out_valid), 16'd0);

    // Reset pulse between edges
    set_words(16'd500, 16'd350, 16'd150, 16'd10);
    sel_valid = 1'b1;
    ctrlSlct = 2'd1;
    cycle();
    check("mid_pre", muxOut, 16'd350);
    #1 rst_n = 1'b0;
    #1;
    check("mid_reg", muxOut, 16'd0);
    check("mid_valid", W'(out_valid), 16'd0);
    rst_n = 1'b1;
    ctrlSlct = 2'd3;
    #1;
    check("mid_before_edge", muxOut, 16'd0);
    cycle();
    check("mid_after", muxOut, 16'd10);
    check("mid_after_valid", W'(out_valid), 16'd1);

    // Full-width words alternate untouched
    in4 = 16'hFFFF; in1 = 16'h0001;
    for (int k = 0; k < 6; k++) begin
      ctrlSlct = (k % 2 == 0) ? 2'd3 : 2'd0;
      cycle();
      check("full_width", muxOut, (k % 2 == 0) ? 16'hFFFF : 16'h0001);
    end

    // Randomized traffic checked by the model every cycle
    for (int k = 0; k < 400; k++) begin
      set_words(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      ctrlSlct = 2'($urandom_range(0, 3));
      sel_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cycle();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mux_two_bit_reg.md
Name: mux_two_bit_reg

Overview:
- 4:1 word selector for the datapath (ALU operand / writeback source selection).
- A 2-bit select code picks one of four WIDTH-bit inputs.
- The selected word is available combinationally and as a registered copy with a valid flag, so it can sit directly in a pipeline stage.
- Single clock domain.

Parameters:
- WIDTH, 16: data width of every input and output word.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in1  input  WIDTH  candidate word, selected by code 0.
- in2  input  WIDTH  candidate word, selected by code 1.
- in3  input  WIDTH  candidate word, selected by code 2.
- in4  input  WIDTH  candidate word, selected by code 3.
- ctrlSlct  input  2  select code.
- sel_valid  input  1  qualifies ctrlSlct/inputs for capture into the output register.
- muxOut_comb  output  WIDTH  combinational selected word, no latency.
- muxOut  output  WIDTH  registered selected word.
- out_valid  output  1  high for one cycle after each captured selection.

Behaviour:
- Select map, all four codes legal, no default/X branch:
  - 0 -> in1
  - 1 -> in2
  - 2 -> in3
  - 3 -> in4
- muxOut_comb:
  - Pure combinational function of ctrlSlct and in1..in4.
  - Updates within the same delta as the inputs.
  - Unaffected by rst_n and clk.
- Registered path, rising clk edge:
  - sel_valid=1: muxOut <= the selected word; out_valid <= 1.
  - sel_valid=0: muxOut holds its previous value; out_valid <= 0.
- Latency: muxOut reflects inputs sampled at edge N, visible after edge N; one cycle after muxOut_comb.
- Reset:
  - rst_n=0 forces muxOut=0 and out_valid=0 immediately, without waiting for a clock edge.
  - Held while rst_n is low.
  - First capture occurs at the first rising edge with rst_n=1 and sel_valid=1.
- Reset asserted mid-stream: the pending capture is discarded; the registered outputs go to 0 at once.
- Input equality: identical values on several inputs must not affect selection; the output is simply that value.
- No arithmetic, no width conversion: the output width equals the input width and bits pass through unchanged.
- ctrlSlct changing every cycle with sel_valid=1 produces a new registered word every cycle; no bubbles.

Decomposition:
- Shared package: WIDTH default, plus select-code constants.
  - SEL_IN1=2'd0, SEL_IN2=2'd1, SEL_IN3=2'd2, SEL_IN4=2'd3.
  - Decoders that drive ctrlSlct use the same constants.
- One sub-module: mux4_comb, a combinational WIDTH-bit 4:1 selector.
  - Its output feeds muxOut_comb directly and the D input of the output register.
- The top level holds only the register, the valid flag and the reset logic.

Test Plan:
- Reset: rst_n=0 with in1=500, sel_valid=1 -> muxOut=0, out_valid=0 asynchronously and with no clock edge. muxOut_comb=500 when ctrlSlct=0.
- Sweep: in1=500, in2=350, in3=150, in4=10, sel_valid=1, ctrlSlct 0,1,2,3 on consecutive cycles:
  - muxOut_comb = 500, 350, 150, 10 in the same cycle.
  - muxOut = the same sequence, one cycle later.
  - out_valid=1 throughout.
- Equal inputs: in1=in2=300, in3=100, in4=1000, ctrlSlct=0 -> 300. Then in3=in4=150, ctrlSlct=1 -> 300. Then ctrlSlct=3 -> 150.
- Hold: capture 350 (ctrlSlct=1), then sel_valid=0 while in2 is changed to 77 and ctrlSlct to 2:
  - muxOut stays 350 and out_valid=0.
  - muxOut_comb=150.
- Mid-stream reset: sel_valid=1 with streaming selections, pulse rst_n low between edges -> muxOut=0 and out_valid=0 immediately. After release, the next captured word (ctrlSlct=3 -> 10) appears one edge later.
- Full width: in4=16'hFFFF, in1=16'h0001, ctrlSlct alternating 3/0 -> outputs alternate FFFF/0001 exactly, with no truncation.
